fifo_wr_arbiter: RTL and testbench

- Shares one 16-bit x 32-entry `fifo` instance between N producer ports and one consumer port.
- Round-robin write arbitration with bounded bursts.
- Drives the FIFO's wr_en/buf_in/rd_en and keeps a shadow occupancy count, because the FIFO exposes no full/empty status.
- Caps occupancy at DEPTH-1 so the FIFO's BUF_WIDTH-bit counter never wraps.

---
 rtl/fifo_wr_arbiter_if.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producer/consumer side and fifo_wr_arbiter.
// The arbiter sits on the slave modport; the producer/consumer side (or a
// bench) uses the master modport. The fifo_* signals go on to the shared fifo.
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       gnt;
    logic               rd_req;
    logic               rd_valid;
    logic               fifo_wr_en;
    logic [WIDTH-1:0]   fifo_din;
    logic               fifo_rd_en;
    logic [OCC_W-1:0]   occupancy;
    logic               empty;
    logic               full;
    logic               almost_full;

    modport master (
        output req, req_data, rd_req,
        input  gnt, rd_valid, fifo_wr_en, fifo_din, fifo_rd_en,
        input  occupancy, empty, full, almost_full
    );

    modport slave (
        input  req, req_data, rd_req,
        output gnt, rd_valid, fifo_wr_en, fifo_din, fifo_rd_en,
        output occupancy, empty, full, almost_full
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one fifo between N producers.
// Grants run in bursts of at most BURST_LEN beats, and each burst ends with
// a one-cycle release bubble. The fifo has no status outputs, so a shadow
// occupancy count is kept here. That count is capped at DEPTH-1, which keeps
// the fifo's internal counter from wrapping.
// Optional feature macro: FIFO_ARB_WATERMARK_EN. When it is defined, a
// registered almost_full flag blocks new bursts once occupancy >= AF_LEVEL.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int BURST_LEN = 4,
    parameter int AF_LEVEL  = 24
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(N);
    localparam logic [OCC_W-1:0] CAP      = OCC_W'(DEPTH - 1);
    localparam logic [3:0]       BEAT_MAX = 4'(BURST_LEN);

    if (N < 2 || N > 8 || BURST_LEN < 1 || BURST_LEN > 15 ||
        AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_param_check
        $error("fifo_wr_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic [PTR_W-1:0] last_owner, last_owner_nxt;
    logic [PTR_W-1:0] winner;
    logic [3:0]       beat_cnt, beat_nxt;
    logic [OCC_W-1:0] occupancy, occ_nxt;
    logic             rd_valid;
    logic             almost_full;
    logic             af_block;
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] din;
    logic             space, found, wr_en, rd_en;
    int               cand;

    // Only the registered count decides space; a pop in the same cycle does not free a slot.
    assign space = (occupancy < CAP);
    assign wr_en = |gnt;
    assign rd_en = bus.rd_req && (occupancy != '0) && !rst;

    // Round-robin search for the first requester after last_owner.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_owner) + k) % N;
            if (!found && bus.req[PTR_W'(cand)]) begin
                winner = PTR_W'(cand);
                found  = 1'b1;
            end
        end
    end

    // Arbitration FSM: next state and grant.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_nxt       = beat_cnt;
        gnt            = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (found && space && !af_block) begin
                        gnt[winner] = 1'b1;
                        owner_nxt   = winner;
                        beat_nxt    = 4'd1;
                        state_nxt   = BURST;
                    end
                end
                BURST: begin
                    if (!bus.req[owner] || beat_cnt == BEAT_MAX) begin
                        // The release cycle is always a bubble.
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end else if (space) begin
                        gnt[owner] = 1'b1;
                        beat_nxt   = beat_cnt + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Data mux for the granted port; drives zero when no port is granted.
    always_comb begin
        din = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) din = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Shadow occupancy: a write together with a read leaves the count unchanged.
    always_comb begin
        unique case ({wr_en, rd_en})
            2'b10:   occ_nxt = occupancy + 1'b1;
            2'b01:   occ_nxt = occupancy - 1'b1;
            default: occ_nxt = occupancy;
        endcase
    end

    // State, owner and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge.
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= PTR_W'(N - 1);
            beat_cnt   <= '0;
            occupancy  <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_nxt;
            occupancy  <= occ_nxt;
            rd_valid   <= rd_en;
        end
    end

`ifdef FIFO_ARB_WATERMARK_EN
    // Watermark flag is registered from the next occupancy value.
    always_ff @(posedge clk) begin
        if (rst) almost_full <= 1'b0;
        else     almost_full <= (occ_nxt >= OCC_W'(AF_LEVEL));
    end
    assign af_block = almost_full;
`else
    assign almost_full = 1'b0;
    assign af_block    = 1'b0;
`endif

    assign bus.gnt         = gnt;
    assign bus.fifo_wr_en  = wr_en;
    assign bus.fifo_din    = din;
    assign bus.fifo_rd_en  = rd_en;
    assign bus.rd_valid    = rd_valid;
    assign bus.occupancy   = occupancy;
    assign bus.empty       = (occupancy == '0);
    assign bus.full        = (occupancy == CAP);
    assign bus.almost_full = almost_full;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter. A behavioural 32-entry fifo with a
// registered buf_out sits on the fifo_* side, so popped data can be checked.
module tb_fifo_wr_arbiter;
    localparam int N = 4, WIDTH = 16, DEPTH = 32, BURST_LEN = 4, AF_LEVEL = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_wr_arbiter #(
        .N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural model of the shared fifo.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [4:0]       wp, rp;
    logic [WIDTH-1:0] buf_out;
    always @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; buf_out <= '0;
        end else begin
            if (bus.fifo_wr_en) begin mem[wp] <= bus.fifo_din; wp <= wp + 5'd1; end
            if (bus.fifo_rd_en) begin buf_out <= mem[rp]; rp <= rp + 5'd1; end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int port, input logic [WIDTH-1:0] v);
        bus.req_data[port*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '1; bus.rd_req = 1'b1; bus.req_data = '0;
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        tick();
        rst = 1'b0; bus.req = '0; bus.rd_req = 1'b0;
        check("rst_occ", bus.occupancy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_af", bus.almost_full, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp1 [6];
        logic [3:0] eg;
        int val;
        logic g;

        // Single producer: four beats, a bubble, then a new burst.
        do_reset();
        exp1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 6; c++) begin
            bus.req = 4'b0001;
            set_data(0, 16'hA000 + 16'(c));
            #1;
            check("s1_gnt", bus.gnt, exp1[c] ? 4'b0001 : 4'b0000);
            check("s1_din", bus.fifo_din, exp1[c] ? 16'hA000 + 16'(c) : 16'h0000);
            tick();
        end
        bus.req = '0;
        check("s1_occ", bus.occupancy, 5);

        // All four ports request: each gets four beats, then a bubble.
        do_reset();
        for (int c = 0; c < 21; c++) begin
            bus.req = 4'b1111;
            for (int p = 0; p < N; p++) set_data(p, 16'hB000 + 16'(p * 256 + c));
            #1;
            eg = (c % 5 == 4) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
            check("s2_gnt", bus.gnt, eg);
            tick();
        end
        bus.req = '0;
        check("s2_occ", bus.occupancy, 17);

        // Fill to capacity, stall while full, then one read frees a slot.
        do_reset();
        val = 1;
        for (int c = 0; c < 80 && bus.occupancy != 31; c++) begin
            bus.req = 4'b0010;
            set_data(1, 16'(val));
            #1;
            g = bus.gnt[1];
            tick();
            if (g) val++;
        end
        check("s3_occ", bus.occupancy, 31);
        check("s3_full", bus.full, 1);
        check("s3_writes", val - 1, 31);
        check("s3_af_off", bus.almost_full, 0);
        for (int c = 0; c < 3; c++) begin
            bus.req = 4'b0010;
            set_data(1, 16'(val));
            #1;
            check("s3_gnt_full", bus.gnt, 0);
            tick();
        end
        check("s3_occ_hold", bus.occupancy, 31);
        bus.rd_req = 1'b1;
        #1;
        check("s3_rd_en", bus.fifo_rd_en, 1);
        check("s3_gnt_rd", bus.gnt, 0);
        tick();
        bus.rd_req = 1'b0;
        check("s3_occ_rd", bus.occupancy, 30);
        check("s3_rd_valid", bus.rd_valid, 1);
        check("s3_pop", buf_out, 16'h0001);
        #1;
        check("s3_gnt_resume", bus.gnt, 4'b0010);
        check("s3_din_resume", bus.fifo_din, 16'd32);
        tick();
        bus.req = '0;
        check("s3_occ_refill", bus.occupancy, 31);

        // One write, then a read; rd_valid and the popped data follow one cycle later.
        do_reset();
        bus.req = 4'b0100;
        set_data(2, 16'h1234);
        #1;
        check("s4_gnt", bus.gnt, 4'b0100);
        tick();
        bus.req = '0; bus.rd_req = 1'b1;
        #1;
        check("s4_rd_en", bus.fifo_rd_en, 1);
        tick();
        check("s4_rd_valid", bus.rd_valid, 1);
        check("s4_pop", buf_out, 16'h1234);
        check("s4_empty", bus.empty, 1);
        #1;
        check("s4_rd_en_empty", bus.fifo_rd_en, 0);
        tick();
        bus.rd_req = 1'b0;
        check("s4_occ_no_underflow", bus.occupancy, 0);
        check("s4_rd_valid_off", bus.rd_valid, 0);

        // Occupancy 10 with continuous write and read: it falls by one per bubble.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus.req = 4'b0001;
            set_data(0, 16'hC000 + 16'(c));
            tick();
        end
        bus.req = '0;
        check("s5_occ_setup", bus.occupancy, 10);
        tick();
        for (int c = 0; c < 15; c++) begin
            bus.req = 4'b0001; bus.rd_req = 1'b1;
            set_data(0, 16'hD000 + 16'(c));
            #1;
            check("s5_gnt", bus.gnt, (c % 5 == 4) ? 4'b0000 : 4'b0001);
            tick();
            check("s5_occ", bus.occupancy, 10 - (c + 1) / 5);
            if (c == 0) check("s5_pop0", buf_out, 16'hC000);
        end
        bus.req = '0; bus.rd_req = 1'b0;

        // Reset in the second beat of a port-2 burst.
        do_reset();
        bus.req = 4'b0100;
        set_data(2, 16'hE000);
        #1;
        check("s6_gnt_first", bus.gnt, 4'b0100);
        tick();
        rst = 1'b1;
        #1;
        check("s6_gnt_in_rst", bus.gnt, 0);
        tick();
        rst = 1'b0;
        check("s6_occ", bus.occupancy, 0);
        bus.req = 4'b0101;
        set_data(0, 16'hE100);
        #1;
        check("s6_gnt_port0", bus.gnt, 4'b0001);
        tick();
        #1;
        check("s6_gnt_port0_b2", bus.gnt, 4'b0001);
        tick();
        bus.req = '0;

`ifdef FIFO_ARB_WATERMARK_EN
        // Watermark: new bursts stop at AF_LEVEL and resume once below it.
        do_reset();
        for (int c = 0; c < 60 && bus.occupancy != 24; c++) begin
            bus.req = 4'b1000;
            set_data(3, 16'hF000 + 16'(c));
            tick();
        end
        check("s7_occ", bus.occupancy, 24);
        check("s7_af", bus.almost_full, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("s7_gnt_blocked", bus.gnt, 0);
            tick();
        end
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("s7_occ_rd", bus.occupancy, 23);
        check("s7_af_clear", bus.almost_full, 0);
        #1;
        check("s7_gnt_resume", bus.gnt, 4'b1000);
        tick();
        bus.req = '0;
        check("s7_af_again", bus.almost_full, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
